// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - shared types and constants for the write-back arbiter
package writeback_pkg;

  localparam int REG_ADDR_W           = 5;
  localparam int XLEN                 = 32;
  localparam int NUM_REGS             = 1 << REG_ADDR_W;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/writeback_fifo.sv
// rtl/writeback_fifo.sv - synchronous result buffer for long-latency write-backs
module writeback_fifo
  import writeback_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_push_entry,
  input  logic               i_pop,
  output logic               o_full,
  output logic               o_empty,
  output logic [ENTRY_W-1:0] o_head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic               w_push;
  logic               w_pop;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointer advance; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_entry;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges ALU and buffered LSU results onto the register-file write port; bypass outputs enabled by WB_BYPASS_EN
module writeback_arbiter
  import writeback_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  wb_stall,
  output logic                  reg_write_enable,
  output logic [REG_ADDR_W-1:0] write_address,
  output logic [XLEN-1:0]       write_data,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [XLEN-1:0]       fwd_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t             w_alu_entry;
  wb_entry_t             w_lsu_entry;
  wb_entry_t             w_head;
  wb_entry_t             w_sel;
  logic [ENTRY_W-1:0]    w_head_bits;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_sel_alu;
  logic                  w_sel_valid;
  logic [NUM_REGS-1:0]   w_set;
  logic [NUM_REGS-1:0]   w_clr;

  logic                  r_wb_stall;
  logic [CNT_W-1:0]      r_starve_cnt;
  logic                  r_we;
  logic                  r_from_fifo;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]       r_data;
  logic [NUM_REGS-1:0]   r_busy;

  assign w_alu_entry = '{rd: alu_rd, data: alu_data};
  assign w_lsu_entry = '{rd: lsu_rd, data: lsu_data};
  assign w_head      = wb_entry_t'(w_head_bits);

  // Ready comes straight from registered pointers, so a same-cycle pop never frees a slot.
  assign lsu_ready   = !w_fifo_full;
  assign w_push      = lsu_valid && !w_fifo_full;

  // A stall cycle reserves the write port for the buffered head.
  assign w_sel_alu   = alu_valid && !r_wb_stall;
  assign w_pop       = !w_fifo_empty && !w_sel_alu;
  assign w_sel_valid = w_sel_alu || w_pop;

  writeback_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_push       (w_push),
    .i_push_entry (w_lsu_entry),
    .i_pop        (w_pop),
    .o_full       (w_fifo_full),
    .o_empty      (w_fifo_empty),
    .o_head       (w_head_bits)
  );

  // Select the write-port source for this cycle.
  always_comb begin
    w_sel = '0;
    if (w_sel_alu)  w_sel = w_alu_entry;
    else if (w_pop) w_sel = w_head;
  end

  // Register the selected result; x0 targets are consumed without a write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_we        <= 1'b0;
      r_from_fifo <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      r_we        <= w_sel_valid && (w_sel.rd != '0);
      r_from_fifo <= w_pop;
      r_addr      <= w_sel.rd;
      r_data      <= w_sel.data;
    end
  end

  // Count consecutive ALU wins over a waiting head; fire a one-cycle stall at the limit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
      r_wb_stall   <= 1'b0;
    end else begin
      r_wb_stall <= 1'b0;
      if (w_fifo_empty || w_pop) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
        r_starve_cnt <= '0;
        r_wb_stall   <= 1'b1;
      end else begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

  assign w_set = (issue_valid && (issue_rd != '0)) ? (NUM_REGS'(1) << issue_rd) : '0;
  assign w_clr = (r_we && r_from_fifo) ? (NUM_REGS'(1) << r_addr) : '0;

  // Pending long-latency destinations; a new issue wins over a retiring write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~NUM_REGS'(1);
    end
  end

  assign busy             = r_busy;
  assign wb_stall         = r_wb_stall;
  assign reg_write_enable = r_we;
  assign write_address    = r_addr;
  assign write_data       = r_data;

`ifdef WB_BYPASS_EN
  assign fwd_valid = r_we;
  assign fwd_addr  = r_addr;
  assign fwd_data  = r_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        wb_stall;
  logic        reg_write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;

  int vectors = 0;
  int miscompares = 0;

  writeback_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .alu_valid        (alu_valid),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .lsu_valid        (lsu_valid),
    .lsu_ready        (lsu_ready),
    .lsu_rd           (lsu_rd),
    .lsu_data         (lsu_data),
    .issue_valid      (issue_valid),
    .issue_rd         (issue_rd),
    .busy             (busy),
    .wb_stall         (wb_stall),
    .reg_write_enable (reg_write_enable),
    .write_address    (write_address),
    .write_data       (write_data),
    .fwd_valid        (fwd_valid),
    .fwd_addr         (fwd_addr),
    .fwd_data         (fwd_data)
  );

  always #5 clk = ~clk;

  // Per-cycle bypass and stall-protocol checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      vectors++;
`ifdef WB_BYPASS_EN
      if ({fwd_valid, fwd_addr, fwd_data} !== {reg_write_enable, write_address, write_data}) begin
        miscompares++;
        $display("FAIL bypass_mirror: got %b/%0d/%h required %b/%0d/%h", fwd_valid, fwd_addr, fwd_data,
                 reg_write_enable, write_address, write_data);
      end
`else
      if ({fwd_valid, fwd_addr, fwd_data} !== 38'd0) begin
        miscompares++;
        $display("FAIL bypass_tied: got %b/%0d/%h required 0", fwd_valid, fwd_addr, fwd_data);
      end
`endif
      if (wb_stall === 1'b1 && alu_valid === 1'b1) begin
        miscompares++;
        $display("FAIL stall_protocol: alu_valid=1 during wb_stall");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid   = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid   = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    vectors++;
    if ({reg_write_enable, write_address, write_data} !== 38'd0) begin
      miscompares++;
      $display("FAIL reset_port: got %b/%0d/%h required 0", reg_write_enable, write_address, write_data);
    end
    vectors++;
    if (busy !== 32'd0 || wb_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy_stall: got %h/%b required 0/0", busy, wb_stall);
    end
    vectors++;
    if (lsu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b required 1", lsu_ready);
    end
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick();
    idle();
    vectors++;
    if ({reg_write_enable, write_address, write_data} !== {1'b1, 5'd5, 32'h1234}) begin
      miscompares++;
      $display("FAIL alu_write: got %b/%0d/%h required 1/5/1234", reg_write_enable, write_address, write_data);
    end
    vectors++;
    if (busy !== 32'd0) begin
      miscompares++;
      $display("FAIL alu_busy: got %h required 0", busy);
    end
    tick();
    vectors++;
    if (reg_write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_idle: got %b required 0", reg_write_enable);
    end
  endtask

  task automatic test_issue_lsu();
    issue_valid = 1'b1; issue_rd = 5'd10;
    tick();
    idle();
    vectors++;
    if (busy !== 32'h0000_0400) begin
      miscompares++;
      $display("FAIL issue_busy_set: got %h required 00000400", busy);
    end
    tick(); tick();
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hDEADBEEF;
    tick();
    idle();
    vectors++;
    if (reg_write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL lsu_no_fallthrough: got %b required 0", reg_write_enable);
    end
    tick();
    vectors++;
    if ({reg_write_enable, write_address, write_data} !== {1'b1, 5'd10, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL lsu_write: got %b/%0d/%h required 1/10/deadbeef", reg_write_enable, write_address, write_data);
    end
    vectors++;
    if (busy !== 32'h0000_0400) begin
      miscompares++;
      $display("FAIL busy_held_during_write: got %h required 00000400", busy);
    end
    tick();
    vectors++;
    if (busy !== 32'd0 || reg_write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_cleared: got %h/%b required 0/0", busy, reg_write_enable);
    end
  endtask

  task automatic test_fifo_full();
    logic [4:0]  exp_addr [5];
    logic [31:0] exp_data [5];
    logic        exp_ready [5];
    exp_addr  = '{5'd1, 5'd2, 5'd3, 5'd11, 5'd12};
    exp_data  = '{32'h100, 32'h200, 32'h300, 32'hA1, 32'hA2};
    exp_ready = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = 32'((i + 1) * 32'h100);
        lsu_valid = 1'b1; lsu_rd = 5'(11 + i); lsu_data = 32'(32'hA1 + i);
      end else begin
        idle();
      end
      tick();
      vectors++;
      if ({reg_write_enable, write_address, write_data} !== {1'b1, exp_addr[i], exp_data[i]}) begin
        miscompares++;
        $display("FAIL full_order_%0d: got %b/%0d/%h required 1/%0d/%h", i, reg_write_enable, write_address,
                 write_data, exp_addr[i], exp_data[i]);
      end
      vectors++;
      if (lsu_ready !== exp_ready[i] || wb_stall !== 1'b0) begin
        miscompares++;
        $display("FAIL full_ready_%0d: got %b/%b required %b/0", i, lsu_ready, wb_stall, exp_ready[i]);
      end
    end
    tick();
    vectors++;
    if (reg_write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL full_refused_dropped: got %b/%0d required 0", reg_write_enable, write_address);
    end
  endtask

  task automatic test_starvation();
    lsu_valid = 1'b1; lsu_rd = 5'd14; lsu_data = 32'h5555;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'(32'h31 + i);
      tick();
      vectors++;
      if (wb_stall !== (i == 3)) begin
        miscompares++;
        $display("FAIL starve_stall_%0d: got %b required %b", i, wb_stall, (i == 3));
      end
    end
    idle();
    vectors++;
    if ({reg_write_enable, write_address, write_data} !== {1'b1, 5'd3, 32'h34}) begin
      miscompares++;
      $display("FAIL starve_last_alu: got %b/%0d/%h required 1/3/34", reg_write_enable, write_address, write_data);
    end
    tick();
    vectors++;
    if ({reg_write_enable, write_address, write_data, wb_stall} !== {1'b1, 5'd14, 32'h5555, 1'b0}) begin
      miscompares++;
      $display("FAIL starve_head_write: got %b/%0d/%h stall=%b required 1/14/5555 stall=0", reg_write_enable,
               write_address, write_data, wb_stall);
    end
    tick();
    vectors++;
    if (reg_write_enable !== 1'b0 || wb_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL starve_drained: got %b/%b required 0/0", reg_write_enable, wb_stall);
    end
  endtask

  task automatic test_rd0_collision();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    vectors++;
    if (busy !== 32'h0000_0080) begin
      miscompares++;
      $display("FAIL rd7_busy_set: got %h required 00000080", busy);
    end
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    tick();
    idle();
    vectors++;
    if (reg_write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL rd0_no_write: got %b/%0d required 0", reg_write_enable, write_address);
    end
    tick();
    vectors++;
    if ({reg_write_enable, write_address, write_data} !== {1'b1, 5'd7, 32'h77}) begin
      miscompares++;
      $display("FAIL rd7_write: got %b/%0d/%h required 1/7/77", reg_write_enable, write_address, write_data);
    end
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    vectors++;
    if (busy !== 32'h0000_0080) begin
      miscompares++;
      $display("FAIL set_wins_collision: got %h required 00000080", busy);
    end
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h78;
    tick();
    idle();
    tick(); tick();
    vectors++;
    if (busy !== 32'd0) begin
      miscompares++;
      $display("FAIL rd7_busy_cleared: got %h required 0", busy);
    end
  endtask

  task automatic test_mid_reset();
    issue_valid = 1'b1; issue_rd = 5'd10;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h20;
    tick();
    issue_valid = 1'b0;
    vectors++;
    if (busy !== 32'h0000_0400) begin
      miscompares++;
      $display("FAIL mid_busy: got %h required 00000400", busy);
    end
    alu_data = 32'h12; lsu_rd = 5'd21; lsu_data = 32'h21;
    tick();
    idle();
    vectors++;
    if (lsu_ready !== 1'b0 || {reg_write_enable, write_address, write_data} !== {1'b1, 5'd1, 32'h12}) begin
      miscompares++;
      $display("FAIL mid_full: got ready=%b %b/%0d/%h required ready=0 1/1/12", lsu_ready, reg_write_enable,
               write_address, write_data);
    end
    reset_n = 1'b0;
    tick();
    vectors++;
    if ({reg_write_enable, write_address, write_data, wb_stall} !== 39'd0 || busy !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %b/%0d/%h stall=%b busy=%h required 0", reg_write_enable,
               write_address, write_data, wb_stall, busy);
    end
    reset_n = 1'b1;
    tick();
    vectors++;
    if (lsu_ready !== 1'b1 || reg_write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_release: got ready=%b we=%b required 1/0", lsu_ready, reg_write_enable);
    end
    tick();
    vectors++;
    if (reg_write_enable !== 1'b0 || busy !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_fifo_discarded: got we=%b busy=%h required 0/0", reg_write_enable, busy);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    test_reset();
    test_alu_only();
    test_issue_lsu();
    test_fifo_full();
    test_starvation();
    test_rd0_collision();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
